// File: rtl/cod5_muldiv_if.sv
// Operand/result bus between the cod5 execute-stage control and the mul/div unit.
interface cod5_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             I_start;
  logic [1:0]       I_func;
  logic [WIDTH-1:0] I_a;
  logic [WIDTH-1:0] I_b;
  logic             O_busy;
  logic             O_done;
  logic [WIDTH-1:0] O_lo;
  logic [WIDTH-1:0] O_hi;

  modport master (
    output I_start, I_func, I_a, I_b,
    input  O_busy, O_done, O_lo, O_hi
  );

  modport slave (
    input  I_start, I_func, I_a, I_b,
    output O_busy, O_done, O_lo, O_hi
  );
endinterface

// File: rtl/cod5_muldiv.sv
// Iterative multiply/divide: WIDTH shift-add or restoring shift-subtract steps on operand
// magnitudes, then one sign/special-case fix cycle. Fixed latency of WIDTH+2 cycles.
module cod5_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic           I_clk,
  input logic           I_reset,
  cod5_muldiv_if.slave  md_io
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] out_lo_q, out_lo_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;

  logic             start_ok;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;

    start_ok = md_io.I_start && ((state_q == StIdle) || (state_q == StDone));
    a_neg    = md_io.I_func[0] && md_io.I_a[WIDTH-1];
    b_neg    = md_io.I_func[0] && md_io.I_b[WIDTH-1];
    a_mag    = a_neg ? (~md_io.I_a + 1'b1) : md_io.I_a;
    b_mag    = b_neg ? (~md_io.I_b + 1'b1) : md_io.I_b;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};

    prod = {hi_q, lo_q};
    if (qneg_q) prod = ~prod + 1'b1;
    quo = qneg_q ? (~lo_q + 1'b1) : lo_q;
    rem = rneg_q ? (~hi_q + 1'b1) : hi_q;
    // Zero divisor: quotient forced to all ones; remainder path already yields the dividend.
    if (m_q == '0) quo = '1;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d = StRun;
          cnt_d   = CntW'(WIDTH);
          div_d   = md_io.I_func[1];
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          hi_d    = '0;
          // Multiply shifts the multiplier out of lo; divide shifts the dividend out of lo.
          lo_d    = md_io.I_func[1] ? a_mag : b_mag;
          m_d     = md_io.I_func[1] ? b_mag : a_mag;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
        if (div_q) begin
          if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end
      StFix: begin
        state_d = StDone;
        if (div_q) begin
          out_lo_d = quo;
          out_hi_d = rem;
        end else begin
          out_lo_d = prod[WIDTH-1:0];
          out_hi_d = prod[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_lo_q <= '0;
      out_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
    end
  end

  assign md_io.O_busy = (state_q == StRun) || (state_q == StFix);
  assign md_io.O_done = (state_q == StDone);
  assign md_io.O_lo   = out_lo_q;
  assign md_io.O_hi   = out_hi_q;
endmodule

// File: tb/tb_cod5_muldiv.sv
// Scoreboard bench for cod5_muldiv: driver pushes model results, negedge monitor checks them.
module tb_cod5_muldiv;
  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic [31:0] hold_lo = '0;
  logic [31:0] hold_hi = '0;

  cod5_muldiv_if #(.WIDTH(W)) md ();

  cod5_muldiv #(.WIDTH(W)) dut (
    .I_clk   (clk),
    .I_reset (rst),
    .md_io   (md)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [1:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sp;
    int sa, sbv, q, r;
    logic [63:0] res;
    sa  = a;
    sbv = b;
    case (f)
      2'd0: res = {32'b0, a} * {32'b0, b};
      2'd1: begin
        sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res = sp;
      end
      2'd2: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'b0, a};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          res = {r, q};
        end
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs hold the last completed result except on the done cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_lo", md.O_lo, 32'h0);
      chk("rst_hi", md.O_hi, 32'h0);
      chk("rst_done", {31'b0, md.O_done}, 32'h0);
    end else begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        total++;
        bad++;
        $display("FAIL missed_done: got none want done at cycle %0d", sb[0].due);
        void'(sb.pop_front());
      end
      chk("busy", {31'b0, md.O_busy},
          {31'b0, (sb.size() > 0 && cyc + W + 1 >= sb[0].due && cyc < sb[0].due)});
      if (md.O_done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done want none (cycle %0d)", cyc);
        end else begin
          chk("latency", cyc, sb[0].due);
          chk("lo", md.O_lo, sb[0].lo);
          chk("hi", md.O_hi, sb[0].hi);
          hold_lo = sb[0].lo;
          hold_hi = sb[0].hi;
          void'(sb.pop_front());
        end
      end else begin
        chk("hold_lo", md.O_lo, hold_lo);
        chk("hold_hi", md.O_hi, hold_hi);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic scramble();
    md.I_a    = $urandom;
    md.I_b    = $urandom;
    md.I_func = 2'($urandom_range(0, 3));
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    r     = model(f, a, b);
    e.lo  = r[31:0];
    e.hi  = r[63:32];
    e.due = cyc + 1 + W + 1;
    sb.push_back(e);
    md.I_func  = f;
    md.I_a     = a;
    md.I_b     = b;
    md.I_start = 1'b1;
    step();
    md.I_start = 1'b0;
    scramble();
  endtask

  task automatic issue_ignored(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    md.I_func  = f;
    md.I_a     = a;
    md.I_b     = b;
    md.I_start = 1'b1;
    step();
    md.I_start = 1'b0;
    scramble();
  endtask

  task automatic wait_empty();
    int guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      step();
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL wait_empty: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  // Advance to the DONE cycle of the pending op so the next issue is back-to-back.
  task automatic wait_done_cycle();
    int guard = 0;
    while (sb.size() > 0 && cyc != sb[0].due && guard < 200) begin
      step();
      guard++;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[$] = '{
    '{2'd0, 32'h0000_0006, 32'h0000_0007},
    '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{2'd1, 32'hFFFF_FFFE, 32'h0000_0003},
    '{2'd1, 32'h8000_0000, 32'h8000_0000},
    '{2'd2, 32'd100,       32'd7},
    '{2'd3, 32'hFFFF_FFF9, 32'd2},
    '{2'd2, 32'hFFFF_FFF9, 32'd2},
    '{2'd2, 32'd5,         32'd0},
    '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF},
    '{2'd3, 32'hFFFF_FFF9, 32'd0}
  };

  initial begin
    md.I_start = 1'b0;
    scramble();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset mid-run aborts the multiply with no done pulse.
    issue(2'd0, 32'd5, 32'd9);
    repeat (10) step();
    rst = 1'b1;
    sb.delete();
    hold_lo = '0;
    hold_hi = '0;
    repeat (2) step();
    rst = 1'b0;
    repeat (40) step();
    issue(2'd0, 32'd0, 32'd0);
    wait_empty();

    foreach (dir[i]) begin
      issue(dir[i].f, dir[i].a, dir[i].b);
      wait_empty();
    end

    // Start mid-run ignored; start in DONE accepted back-to-back.
    issue(2'd0, 32'd6, 32'd7);
    repeat (10) step();
    issue_ignored(2'd2, 32'd100, 32'd7);
    wait_done_cycle();
    issue(2'd2, 32'd100, 32'd7);
    wait_empty();

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) wait_done_cycle();
      else begin
        wait_empty();
        repeat ($urandom_range(0, 3)) step();
      end
      issue(2'($urandom_range(0, 3)), rnd_op(), rnd_op());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 20)) step();
        issue_ignored(2'($urandom_range(0, 3)), $urandom, $urandom);
      end
    end
    wait_empty();
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
